// File: rtl/cnt_pkg.sv
// Shared types and helpers for the up/down counter.
// The counter mode enum and the terminal-count test live here.
package cnt_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10,
        CNT_RSVD    = 2'b11
    } cnt_mode_e;

    localparam int CNT_W_MAX = 32;

    // Callers zero-extend to CNT_W_MAX, so one helper serves any counter width up to 32.
    // A down count is terminal only at zero; a count above max is first pulled back to max.
    function automatic logic cnt_is_terminal(input logic [CNT_W_MAX-1:0] q,
                                             input logic [CNT_W_MAX-1:0] max,
                                             input logic                 up);
        return up ? (q >= max) : (q == '0);
    endfunction

endpackage

// File: rtl/cnt_updown_mod_if.sv
// Control and status bundle for the up/down counter.
// The master side drives the controls; the slave side is the counter.
interface cnt_updown_mod_if
    import cnt_pkg::*;
#(
    parameter int N     = 8,
    parameter int PRE_W = 4
);
    logic             en;
    logic             up;
    cnt_mode_e        mode;
    logic             clr;
    logic             load;
    logic [N-1:0]     din;
    logic [N-1:0]     max;
    logic [PRE_W-1:0] pre;
    logic [N-1:0]     q;
    logic             tc;
    logic             done;

    modport master (
        output en, up, mode, clr, load, din, max, pre,
        input  q, tc, done
    );

    modport slave (
        input  en, up, mode, clr, load, din, max, pre,
        output q, tc, done
    );
endinterface

// File: rtl/cnt_prescaler.sv
// Clock-enable prescaler: raises tick once every (pre+1) enabled cycles.
// The tick is combinational, so the counter can act on it in the same cycle.
module cnt_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             Clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [PRE_W-1:0] pre,
    output logic             tick
);

    logic [PRE_W-1:0] p;

    assign tick = en && (p == pre);

    // If pre is lowered below p, p keeps counting and wraps through 2^PRE_W to reach it.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            p <= '0;
        end else if (sync_clr) begin
            p <= '0;
        end else if (en) begin
            if (p == pre) p <= '0;
            else          p <= p + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_updown_mod.sv
// General-purpose up/down counter with modulus, wrap/saturate/one-shot modes,
// terminal-count pulse, sticky done flag and built-in prescaler.
module cnt_updown_mod
    import cnt_pkg::*;
#(
    parameter int N     = 8,
    parameter int PRE_W = 4
) (
    input  logic             Clk,
    input  logic             resetn,
    cnt_updown_mod_if.slave  bus
);

    logic [N-1:0] q_r;
    logic         tc_r;
    logic         done_r;
    logic [N-1:0] q_nxt;
    logic         tc_nxt;
    logic         done_nxt;
    logic         tick;
    logic         term;

    cnt_prescaler #(.PRE_W(PRE_W)) u_pre (
        .Clk      (Clk),
        .resetn   (resetn),
        .en       (bus.en),
        .sync_clr (bus.clr | bus.load),
        .pre      (bus.pre),
        .tick     (tick)
    );

    assign term = cnt_is_terminal(CNT_W_MAX'(q_r), CNT_W_MAX'(bus.max), bus.up);

    // A finished one-shot ignores ticks; the reserved mode falls into the wrap branch.
    always_comb begin
        q_nxt    = q_r;
        tc_nxt   = 1'b0;
        done_nxt = done_r;
        if (tick && !done_r) begin
            if (term) begin
                tc_nxt = 1'b1;
                case (bus.mode)
                    CNT_SAT: begin
                        q_nxt = bus.up ? bus.max : '0;
                    end
                    CNT_ONESHOT: begin
                        q_nxt    = bus.up ? bus.max : '0;
                        done_nxt = 1'b1;
                    end
                    default: begin
                        q_nxt = bus.up ? '0 : bus.max;
                    end
                endcase
            end else if (bus.up) begin
                q_nxt = q_r + 1'b1;
            end else if (q_r > bus.max) begin
                q_nxt = bus.max;
            end else begin
                q_nxt = q_r - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.clr) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.load) begin
            q_r    <= bus.din;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            tc_r   <= tc_nxt;
            done_r <= done_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.tc   = tc_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_cnt_updown_mod.sv
// Directed bench for cnt_updown_mod (N=4, PRE_W=4) with hand-computed expectations.
module tb_cnt_updown_mod;
    import cnt_pkg::*;

    localparam int N     = 4;
    localparam int PRE_W = 4;

    logic Clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    cnt_updown_mod_if #(.N(N), .PRE_W(PRE_W)) bus ();

    cnt_updown_mod #(.N(N), .PRE_W(PRE_W)) dut (
        .Clk    (Clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.up = 1'b1; bus.mode = CNT_WRAP; bus.clr = 1'b0;
        bus.load = 1'b0; bus.din = '0; bus.max = 4'd9; bus.pre = '0;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL reset_q: got %0d expected 0", bus.q); end
        n_cmp++; if (bus.tc !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tc: got %0b expected 0", bus.tc); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_q;
        logic         exp_tc;
        bus.max = 4'd9; bus.up = 1'b1; bus.pre = '0; bus.mode = CNT_WRAP; bus.en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_q  = N'(i % 10);
            exp_tc = (i == 10);
            n_cmp++; if (bus.q !== exp_q) begin n_err++; $display("[TB] FAIL wrap_q[%0d]: got %0d expected %0d", i, bus.q, exp_q); end
            n_cmp++; if (bus.tc !== exp_tc) begin n_err++; $display("[TB] FAIL wrap_tc[%0d]: got %0b expected %0b", i, bus.tc, exp_tc); end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_prescale_down();
        logic [N-1:0] seq [5];
        logic [N-1:0] exp_q;
        logic         exp_tc;
        seq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        bus.pre = 4'd2; bus.up = 1'b0; bus.din = 4'd3; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_cmp++; if (bus.q !== 4'd3) begin n_err++; $display("[TB] FAIL pre_load_q: got %0d expected 3", bus.q); end
        bus.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_q  = seq[k / 3];
            exp_tc = (k == 12);
            n_cmp++; if (bus.q !== exp_q) begin n_err++; $display("[TB] FAIL pre_down_q[%0d]: got %0d expected %0d", k, bus.q, exp_q); end
            n_cmp++; if (bus.tc !== exp_tc) begin n_err++; $display("[TB] FAIL pre_down_tc[%0d]: got %0b expected %0b", k, bus.tc, exp_tc); end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_saturate();
        logic exp_tc;
        bus.mode = CNT_SAT; bus.max = 4'd5; bus.pre = '0; bus.up = 1'b1;
        bus.din = 4'd4; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.en = 1'b1;
        // First tick 4->5 is an ordinary step; the next four are parked at the terminal.
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_tc = (k > 1);
            n_cmp++; if (bus.q !== 4'd5) begin n_err++; $display("[TB] FAIL sat_q[%0d]: got %0d expected 5", k, bus.q); end
            n_cmp++; if (bus.tc !== exp_tc) begin n_err++; $display("[TB] FAIL sat_tc[%0d]: got %0b expected %0b", k, bus.tc, exp_tc); end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [N-1:0] exp_q  [6];
        logic         exp_tc [6];
        logic         exp_dn [6];
        exp_q  = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.mode = CNT_ONESHOT; bus.max = 4'd3; bus.up = 1'b1; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL os_clr_q: got %0d expected 0", bus.q); end
        bus.en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++; if (bus.q !== exp_q[k]) begin n_err++; $display("[TB] FAIL os_q[%0d]: got %0d expected %0d", k, bus.q, exp_q[k]); end
            n_cmp++; if (bus.tc !== exp_tc[k]) begin n_err++; $display("[TB] FAIL os_tc[%0d]: got %0b expected %0b", k, bus.tc, exp_tc[k]); end
            n_cmp++; if (bus.done !== exp_dn[k]) begin n_err++; $display("[TB] FAIL os_done[%0d]: got %0b expected %0b", k, bus.done, exp_dn[k]); end
        end
        bus.mode = CNT_WRAP;
        step();
        n_cmp++; if (bus.q !== 4'd3) begin n_err++; $display("[TB] FAIL os_modechg_q: got %0d expected 3", bus.q); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("[TB] FAIL os_modechg_done: got %0b expected 1", bus.done); end
        bus.mode = CNT_ONESHOT; bus.din = 4'd0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL os_reload_q: got %0d expected 0", bus.q); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("[TB] FAIL os_reload_done: got %0b expected 0", bus.done); end
        step();
        n_cmp++; if (bus.q !== 4'd1) begin n_err++; $display("[TB] FAIL os_resume_q: got %0d expected 1", bus.q); end
        bus.en = 1'b0;
    endtask

    task automatic test_priority();
        bus.mode = CNT_WRAP; bus.max = 4'd9; bus.pre = '0; bus.din = 4'd12;
        bus.clr = 1'b1; bus.load = 1'b1;
        step();
        bus.clr = 1'b0; bus.load = 1'b0;
        n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL prio_clr_q: got %0d expected 0", bus.q); end
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_cmp++; if (bus.q !== 4'd12) begin n_err++; $display("[TB] FAIL prio_load_q: got %0d expected 12", bus.q); end
        bus.up = 1'b0; bus.en = 1'b1;
        step();
        bus.en = 1'b0;
        n_cmp++; if (bus.q !== 4'd9) begin n_err++; $display("[TB] FAIL oor_down_q: got %0d expected 9", bus.q); end
        n_cmp++; if (bus.tc !== 1'b0) begin n_err++; $display("[TB] FAIL oor_down_tc: got %0b expected 0", bus.tc); end
        bus.load = 1'b1;
        step();
        bus.load = 1'b0; bus.up = 1'b1; bus.en = 1'b1;
        step();
        bus.en = 1'b0;
        n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL oor_up_q: got %0d expected 0", bus.q); end
        n_cmp++; if (bus.tc !== 1'b1) begin n_err++; $display("[TB] FAIL oor_up_tc: got %0b expected 1", bus.tc); end
    endtask

    task automatic test_max_zero();
        bus.mode = CNT_WRAP; bus.max = 4'd0; bus.up = 1'b1; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.up = 1'b0;
            step();
            n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL max0_q[%0d]: got %0d expected 0", k, bus.q); end
            n_cmp++; if (bus.tc !== 1'b1) begin n_err++; $display("[TB] FAIL max0_tc[%0d]: got %0b expected 1", k, bus.tc); end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [N-1:0] exp_q;
        bus.mode = CNT_ONESHOT; bus.max = 4'd2; bus.up = 1'b1; bus.pre = '0; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.en = 1'b1;
        step(); step(); step();
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("[TB] FAIL ar_pre_done: got %0b expected 1", bus.done); end
        #3;
        resetn = 1'b0;
        #1;
        n_cmp++; if (bus.q !== 4'd0) begin n_err++; $display("[TB] FAIL ar_q: got %0d expected 0", bus.q); end
        n_cmp++; if (bus.tc !== 1'b0) begin n_err++; $display("[TB] FAIL ar_tc: got %0b expected 0", bus.tc); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("[TB] FAIL ar_done: got %0b expected 0", bus.done); end
        step();
        resetn = 1'b1;
        bus.mode = CNT_WRAP; bus.max = 4'd9; bus.pre = 4'd2; bus.en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_q = (k == 3) ? 4'd1 : 4'd0;
            n_cmp++; if (bus.q !== exp_q) begin n_err++; $display("[TB] FAIL ar_first_tick_q[%0d]: got %0d expected %0d", k, bus.q, exp_q); end
        end
        bus.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_prescale_down();
        test_saturate();
        test_oneshot();
        test_priority();
        test_max_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
